// File: rtl/switch_control_param_pkg.sv
// Shared definitions for the Phoenix switch controller: port indices, FSM states,
// routing modes and the round-robin search helper.
package switch_control_pkg;

    localparam int unsigned EAST  = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned SOUTH = 3;
    localparam int unsigned LOCAL = 4;

    localparam int unsigned MaxPorts = 5;
    localparam int unsigned IdxW     = 3;

    localparam int unsigned ROUTE_XY = 0;
    localparam int unsigned ROUTE_YX = 1;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        ROUTE,
        GRANT
    } state_e;

    // First set bit of req at or after ptr, wrapping modulo nport; 0 when none is set.
    function automatic logic [IdxW-1:0] rr_first(input logic [MaxPorts-1:0] req,
                                                 input int unsigned         ptr,
                                                 input int unsigned         nport);
        logic            found;
        logic [IdxW-1:0] idx;
        found    = 1'b0;
        rr_first = '0;
        for (int unsigned k = 0; k < MaxPorts; k++) begin
            if (k < nport) begin
                idx = IdxW'((ptr + k) % nport);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    rr_first = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/switch_control_param_if.sv
// Input-buffer / crossbar side signals of the switch controller.
interface switch_control_param_if #(
    parameter int unsigned NPORT  = 5,
    parameter int unsigned FLIT_W = 16,
    parameter int unsigned SEL_W  = $clog2(NPORT)
);
    logic [NPORT-1:0]        h;
    logic [NPORT-1:0]        ack_h;
    logic [NPORT*FLIT_W-1:0] data_in;
    logic [NPORT-1:0]        sender;
    logic [NPORT-1:0]        free;
    logic [NPORT*SEL_W-1:0]  mux_in;
    logic [NPORT*SEL_W-1:0]  mux_out;

    // Buffers/crossbar side.
    modport master (
        output h, data_in, sender,
        input  ack_h, free, mux_in, mux_out
    );

    // Controller side.
    modport slave (
        input  h, data_in, sender,
        output ack_h, free, mux_in, mux_out
    );
endinterface

// File: rtl/switch_control_param_dor_route_calc.sv
// Dimension-order route calculator: maps a target XY address to an output port index.
module dor_route_calc
    import switch_control_pkg::*;
#(
    parameter int unsigned          COORD_W      = 4,
    parameter logic [2*COORD_W-1:0] ADDRESS      = 8'h11,
    parameter int unsigned          ROUTING_MODE = ROUTE_XY,
    parameter int unsigned          SEL_W        = 3
) (
    input  logic [2*COORD_W-1:0] target_i,
    output logic [SEL_W-1:0]     port_o
);

    localparam logic [COORD_W-1:0] LocalX = ADDRESS[2*COORD_W-1:COORD_W];
    localparam logic [COORD_W-1:0] LocalY = ADDRESS[COORD_W-1:0];

    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;

    assign tx = target_i[2*COORD_W-1:COORD_W];
    assign ty = target_i[COORD_W-1:0];

    always_comb begin
        port_o = SEL_W'(LOCAL);
        if (ROUTING_MODE == ROUTE_XY) begin
            if (tx > LocalX)      port_o = SEL_W'(EAST);
            else if (tx < LocalX) port_o = SEL_W'(WEST);
            else if (ty > LocalY) port_o = SEL_W'(NORTH);
            else if (ty < LocalY) port_o = SEL_W'(SOUTH);
        end else begin
            if (ty > LocalY)      port_o = SEL_W'(NORTH);
            else if (ty < LocalY) port_o = SEL_W'(SOUTH);
            else if (tx > LocalX) port_o = SEL_W'(EAST);
            else if (tx < LocalX) port_o = SEL_W'(WEST);
        end
    end

endmodule

// File: rtl/switch_control_param.sv
// Phoenix NoC switch controller: round-robin header arbitration, in-block DOR routing and
// a per-input connection table driving the crossbar muxes.
module switch_control_param
    import switch_control_pkg::*;
#(
    parameter int unsigned          NPORT        = 5,
    parameter int unsigned          FLIT_W       = 16,
    parameter int unsigned          COORD_W      = FLIT_W / 4,
    parameter logic [2*COORD_W-1:0] ADDRESS      = 8'h11,
    parameter int unsigned          ROUTING_MODE = ROUTE_XY,
    parameter int unsigned          SEL_W        = $clog2(NPORT)
) (
    input logic                   clock,
    input logic                   reset,
    switch_control_param_if.slave bus_io
);

    state_e                       state_q, state_d;
    logic [SEL_W-1:0]             sel_q, sel_d;
    logic [SEL_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NPORT-1:0]             free_q, free_d;
    logic [NPORT-1:0]             conn_valid_q, conn_valid_d;
    logic [NPORT-1:0]             sender_q;
    logic [NPORT-1:0][SEL_W-1:0]  mux_in_q, mux_in_d;
    logic [NPORT-1:0][SEL_W-1:0]  mux_out_q, mux_out_d;
    logic [NPORT-1:0]             ack_h;

    logic [2*COORD_W-1:0]         route_target;
    logic [SEL_W-1:0]             route_dir;
    logic                         dir_free;
    logic [SEL_W-1:0]             next_ptr;

    assign route_target = bus_io.data_in[32'(sel_q) * FLIT_W +: 2*COORD_W];

    dor_route_calc #(
        .COORD_W      (COORD_W),
        .ADDRESS      (ADDRESS),
        .ROUTING_MODE (ROUTING_MODE),
        .SEL_W        (SEL_W)
    ) u_route (
        .target_i (route_target),
        .port_o   (route_dir)
    );

    // A route pointing past the last implemented port is treated as busy.
    assign dir_free = (32'(route_dir) < NPORT) && free_q[route_dir];
    assign next_ptr = (sel_q == SEL_W'(NPORT - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        free_d       = free_q;
        conn_valid_d = conn_valid_q;
        mux_in_d     = mux_in_q;
        mux_out_d    = mux_out_q;
        ack_h        = '0;

        // Releases go first so a grant to a re-requesting input overrides its own release.
        for (int i = 0; i < NPORT; i++) begin
            if (sender_q[i] && !bus_io.sender[i] && conn_valid_q[i]) begin
                free_d[mux_in_q[i]] = 1'b1;
                conn_valid_d[i]     = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (|bus_io.h) state_d = ARB;
            end
            ARB: begin
                if (|bus_io.h) begin
                    sel_d   = SEL_W'(rr_first(MaxPorts'(bus_io.h), 32'(rr_ptr_q), NPORT));
                    state_d = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: begin
                if (dir_free) begin
                    mux_out_d[route_dir] = sel_q;
                    mux_in_d[sel_q]      = route_dir;
                    conn_valid_d[sel_q]  = 1'b1;
                    free_d[route_dir]    = 1'b0;
                    state_d              = GRANT;
                end else begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            GRANT: begin
                ack_h[sel_q] = 1'b1;
                rr_ptr_d     = next_ptr;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            free_q       <= '1;
            conn_valid_q <= '0;
            sender_q     <= '0;
            mux_in_q     <= '0;
            mux_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            free_q       <= free_d;
            conn_valid_q <= conn_valid_d;
            sender_q     <= bus_io.sender;
            mux_in_q     <= mux_in_d;
            mux_out_q    <= mux_out_d;
        end
    end

    assign bus_io.ack_h   = ack_h;
    assign bus_io.free    = free_q;
    assign bus_io.mux_in  = mux_in_q;
    assign bus_io.mux_out = mux_out_q;

endmodule

// File: tb/tb_switch_control_param.sv
// Bench for switch_control_param: XY and YX instances share directed stimulus and are
// compared every cycle against a connection-table model, plus literal spot checks.
module tb_switch_control_param;
    import switch_control_pkg::*;

    localparam int unsigned NP   = 5;
    localparam int unsigned FW   = 16;
    localparam int unsigned SW   = 3;
    localparam logic [7:0]  ADDR = 8'h11;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    h;
    logic [NP-1:0]    sender;
    logic [NP*FW-1:0] data_in;
    bit               chk_en;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    switch_control_param_if #(.NPORT(NP), .FLIT_W(FW), .SEL_W(SW)) bus_xy ();
    switch_control_param_if #(.NPORT(NP), .FLIT_W(FW), .SEL_W(SW)) bus_yx ();

    assign bus_xy.h       = h;
    assign bus_xy.sender  = sender;
    assign bus_xy.data_in = data_in;
    assign bus_yx.h       = h;
    assign bus_yx.sender  = sender;
    assign bus_yx.data_in = data_in;

    switch_control_param #(
        .NPORT(NP), .FLIT_W(FW), .ADDRESS(ADDR), .ROUTING_MODE(ROUTE_XY), .SEL_W(SW)
    ) dut_xy (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus_xy)
    );

    switch_control_param #(
        .NPORT(NP), .FLIT_W(FW), .ADDRESS(ADDR), .ROUTING_MODE(ROUTE_YX), .SEL_W(SW)
    ) dut_yx (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus_yx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model: connection table, index 0 = XY, 1 = YX ----------------
    int            phase [2];   // cycles into a transaction: 0 idle .. 3 grant
    int            msel  [2];
    int            rr    [2];
    int            owner [2][NP];
    int            conn  [2][NP];
    int            mi    [2][NP];
    int            mo    [2][NP];
    logic [NP-1:0] sq    [2];

    function automatic int route_f(input int mode, input int tgt);
        int x, y, tx, ty;
        x  = int'(ADDR) / 16;
        y  = int'(ADDR) % 16;
        tx = tgt / 16;
        ty = tgt % 16;
        if (mode == 0) begin
            if (tx > x) return int'(EAST);
            if (tx < x) return int'(WEST);
            if (ty > y) return int'(NORTH);
            if (ty < y) return int'(SOUTH);
        end else begin
            if (ty > y) return int'(NORTH);
            if (ty < y) return int'(SOUTH);
            if (tx > x) return int'(EAST);
            if (tx < x) return int'(WEST);
        end
        return int'(LOCAL);
    endfunction

    task automatic model_step(input int m);
        int               nphase, found, idx, dir, tgt;
        bit               grant;
        logic [NP*FW-1:0] sh;
        if (reset) begin
            phase[m] = 0; msel[m] = 0; rr[m] = 0; sq[m] = '0;
            for (int i = 0; i < NP; i++) begin
                owner[m][i] = -1; conn[m][i] = -1; mi[m][i] = 0; mo[m][i] = 0;
            end
            return;
        end
        nphase = 0;
        grant  = 1'b0;
        dir    = 0;
        case (phase[m])
            0: nphase = (h != '0) ? 1 : 0;
            1: begin
                found = -1;
                for (int k = 0; k < NP; k++) begin
                    idx = (rr[m] + k) % NP;
                    if (found < 0 && h[idx]) found = idx;
                end
                if (found >= 0) begin
                    msel[m] = found;
                    nphase  = 2;
                end
            end
            2: begin
                sh  = data_in >> (msel[m] * FW);
                tgt = int'(sh[7:0]);
                dir = route_f(m, tgt);
                if (owner[m][dir] < 0) begin
                    grant  = 1'b1;
                    nphase = 3;
                end else begin
                    rr[m] = (msel[m] + 1) % NP;
                end
            end
            default: rr[m] = (msel[m] + 1) % NP;
        endcase
        for (int i = 0; i < NP; i++) begin
            if (sq[m][i] && !sender[i] && conn[m][i] >= 0) begin
                owner[m][conn[m][i]] = -1;
                conn[m][i] = -1;
            end
        end
        if (grant) begin
            conn[m][msel[m]] = dir;
            owner[m][dir]    = msel[m];
            mi[m][msel[m]]   = dir;
            mo[m][dir]       = msel[m];
        end
        sq[m]    = sender;
        phase[m] = nphase;
    endtask

    function automatic logic [NP-1:0] exp_ack(input int m);
        logic [NP-1:0] e;
        e = '0;
        if (phase[m] == 3) e[msel[m]] = 1'b1;
        return e;
    endfunction

    function automatic logic [NP-1:0] exp_free(input int m);
        logic [NP-1:0] e;
        for (int o = 0; o < NP; o++) e[o] = (owner[m][o] < 0);
        return e;
    endfunction

    function automatic logic [NP*SW-1:0] exp_mux(input int m, input bit out_side);
        logic [NP*SW-1:0] e;
        e = '0;
        for (int i = 0; i < NP; i++) e[i*SW +: SW] = SW'(out_side ? mo[m][i] : mi[m][i]);
        return e;
    endfunction

    function automatic logic [SW-1:0] fld(input logic [NP*SW-1:0] v, input int idx);
        return v[idx*SW +: SW];
    endfunction

    initial forever begin
        @(posedge clock);
        model_step(0);
        model_step(1);
    end

    task automatic cmp(input int m, input logic [NP-1:0] ack, input logic [NP-1:0] fr,
                       input logic [NP*SW-1:0] mxi, input logic [NP*SW-1:0] mxo);
        string tag;
        tag = (m == 0) ? "xy" : "yx";
        check({tag, "_ack_h"},   32'(ack), 32'(exp_ack(m)));
        check({tag, "_free"},    32'(fr),  32'(exp_free(m)));
        check({tag, "_mux_in"},  32'(mxi), 32'(exp_mux(m, 1'b0)));
        check({tag, "_mux_out"}, 32'(mxo), 32'(exp_mux(m, 1'b1)));
    endtask

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            cmp(0, bus_xy.ack_h, bus_xy.free, bus_xy.mux_in, bus_xy.mux_out);
            cmp(1, bus_yx.ack_h, bus_yx.free, bus_yx.mux_in, bus_yx.mux_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_flit(input int port, input logic [FW-1:0] flit);
        data_in[port*FW +: FW] = flit;
    endtask

    task automatic wait_ack(input int port, input string name, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clock);
            cycles++;
            if (bus_xy.ack_h[port] === 1'b1) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  north_early;
        reset   = 1'b1;
        h       = '0;
        sender  = '0;
        data_in = '0;
        chk_en  = 1'b0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;

        check("rst_ack",     32'(bus_xy.ack_h),   32'd0);
        check("rst_free",    32'(bus_xy.free),    32'(5'b11111));
        check("rst_free_yx", 32'(bus_yx.free),    32'(5'b11111));
        check("rst_mux_in",  32'(bus_xy.mux_in),  32'd0);
        check("rst_mux_out", 32'(bus_xy.mux_out), 32'd0);
        reset = 1'b0;

        // Single grant: LOCAL -> EAST, ack exactly in cycle 3.
        set_flit(LOCAL, 16'h0021);
        h[LOCAL] = 1'b1;
        @(negedge clock);
        check("sg_ack_c1", 32'(bus_xy.ack_h), 32'd0);
        @(negedge clock);
        check("sg_ack_c2", 32'(bus_xy.ack_h), 32'd0);
        @(negedge clock);
        check("sg_ack_c3",    32'(bus_xy.ack_h), 32'(5'b10000));
        check("sg_model_ack", 32'(exp_ack(0)),   32'(5'b10000));
        check("sg_free",      32'(bus_xy.free),  32'(5'b11110));
        check("sg_model_free", 32'(exp_free(0)), 32'(5'b11110));
        check("sg_mux_out_e", 32'(fld(bus_xy.mux_out, EAST)), 32'd4);
        check("sg_mux_in_l",  32'(fld(bus_xy.mux_in, LOCAL)), 32'd0);
        h[LOCAL]      = 1'b0;
        sender[LOCAL] = 1'b1;
        sender[SOUTH] = 1'b1;
        @(negedge clock);
        check("sg_ack_c4", 32'(bus_xy.ack_h), 32'd0);

        // Falling sender on an unconnected input is ignored.
        @(negedge clock);
        sender[SOUTH] = 1'b0;
        repeat (2) @(negedge clock);
        check("south_drop_free", 32'(bus_xy.free), 32'(5'b11110));

        // Releasing LOCAL frees EAST one edge after sender falls.
        sender[LOCAL] = 1'b0;
        check("rel_before", 32'(bus_xy.free), 32'(5'b11110));
        @(negedge clock);
        check("rel_after",  32'(bus_xy.free), 32'(5'b11111));

        // Contention: WEST wins from rr_ptr=0, NORTH blocked on EAST until WEST releases.
        set_flit(WEST, 16'h0021);
        set_flit(NORTH, 16'h0021);
        h[WEST]  = 1'b1;
        h[NORTH] = 1'b1;
        wait_ack(WEST, "west_ack_seen", cyc);
        check("west_ack_latency", 32'(cyc), 32'd3);
        check("west_ack_only",    32'(bus_xy.ack_h), 32'(5'b00010));
        check("west_ack_yx",      32'(bus_yx.ack_h), 32'(5'b00010));
        h[WEST]      = 1'b0;
        sender[WEST] = 1'b1;
        north_early  = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (bus_xy.ack_h[NORTH] !== 1'b0) north_early = 1'b1;
        end
        check("north_blocked", 32'(north_early), 32'd0);
        check("east_busy",     32'(bus_xy.free[EAST]), 32'd0);
        sender[WEST] = 1'b0;
        wait_ack(NORTH, "north_ack_seen", cyc);
        check("north_mux_out_e",    32'(fld(bus_xy.mux_out, EAST)), 32'd2);
        check("north_mux_out_e_yx", 32'(fld(bus_yx.mux_out, EAST)), 32'd2);
        check("north_mux_in_n",     32'(fld(bus_xy.mux_in, NORTH)), 32'd0);
        h[NORTH]      = 1'b0;
        sender[NORTH] = 1'b1;
        repeat (2) @(negedge clock);
        sender[NORTH] = 1'b0;
        repeat (2) @(negedge clock);
        check("cont_all_free", 32'(bus_xy.free), 32'(5'b11111));

        // XY vs YX on the same header.
        set_flit(LOCAL, 16'h0022);
        h[LOCAL] = 1'b1;
        repeat (3) @(negedge clock);
        check("mode_ack_xy",   32'(bus_xy.ack_h), 32'(5'b10000));
        check("mode_ack_yx",   32'(bus_yx.ack_h), 32'(5'b10000));
        check("mode_xy_east",  32'(fld(bus_xy.mux_out, EAST)),  32'd4);
        check("mode_yx_north", 32'(fld(bus_yx.mux_out, NORTH)), 32'd4);
        check("mode_xy_free",  32'(bus_xy.free), 32'(5'b11110));
        check("mode_yx_free",  32'(bus_yx.free), 32'(5'b11011));
        h[LOCAL] = 1'b0;
        repeat (2) @(negedge clock);

        // Reset during ROUTE cancels the grant; request is re-arbitrated afterwards.
        set_flit(EAST, 16'h0001);
        h[EAST] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_ack",     32'(bus_xy.ack_h),   32'd0);
        check("mid_rst_free",    32'(bus_xy.free),    32'(5'b11111));
        check("mid_rst_free_yx", 32'(bus_yx.free),    32'(5'b11111));
        check("mid_rst_mux_in",  32'(bus_xy.mux_in),  32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("re_ack_c1", 32'(bus_xy.ack_h), 32'd0);
        @(negedge clock);
        check("re_ack_c2", 32'(bus_xy.ack_h), 32'd0);
        @(negedge clock);
        check("re_ack_c3",    32'(bus_xy.ack_h), 32'(5'b00001));
        check("re_mux_in_e",  32'(fld(bus_xy.mux_in, EAST)), 32'd1);
        check("re_free",      32'(bus_xy.free), 32'(5'b11101));
        h[EAST] = 1'b0;
        repeat (2) @(negedge clock);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
